ide_target: RTL and testbench

IDE_TARGET -- requirements
Module: ide_target

---
 rtl/ide_target.sv | 130 +++++++++++++
 tb/tb_ide_target.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ide_target.sv
// ide_target: IDE/ATA PIO target that moves 256-word sectors between the host bus and a word-wide memory.
module ide_target #(
  parameter int ADDR_W = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       ide_data_in,
  output logic [15:0]       ide_data_out,
  output logic              ide_data_oe,
  input  logic              ide_dior,
  input  logic              ide_diow,
  input  logic [1:0]        ide_cs,
  input  logic [2:0]        ide_da,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ack
);
  typedef enum logic [2:0] {IDLE, RD_FETCH, RD_XFER, WR_XFER, WR_COMMIT, NEXT} state_t;
  state_t state, state_n;
  logic [6:0] sync_m, sync_s, sync_p;
  logic [15:0] buffer [256];
  logic [7:0] ptr, count, error, status;
  logic [27:0] lba;
  logic [3:0] dh_hi;
  logic err, wr_cmd, busy, drq;
  logic rd_edge, wr_edge, hit, data_rd, data_wr, reg_wr, cmd, go_rd, go_wr, last, adv;
  logic [15:0] rd_mux;

  // bus controls as {dior, diow, cs[1:0], da[2:0]}; sync_p lags one cycle so the edge cycle sees the strobe-low address
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync_m <= 7'b1111000;
      sync_s <= 7'b1111000;
      sync_p <= 7'b1111000;
    end else begin
      sync_m <= {ide_dior, ide_diow, ide_cs, ide_da};
      sync_s <= sync_m;
      sync_p <= sync_s;
    end

  assign rd_edge = sync_s[6] & ~sync_p[6];
  assign wr_edge = sync_s[5] & ~sync_p[5];
  assign hit = sync_p[4:3] == 2'b10;
  assign data_rd = rd_edge & hit & (sync_p[2:0] == 3'd0);
  assign data_wr = wr_edge & hit & (sync_p[2:0] == 3'd0);
  assign reg_wr = wr_edge & hit & (state == IDLE);
  assign cmd = reg_wr & (sync_p[2:0] == 3'd7);
  assign go_rd = cmd & (ide_data_in[7:0] == 8'h20);
  assign go_wr = cmd & (ide_data_in[7:0] == 8'h30);
  assign last = &ptr;
  assign adv = ((state == RD_FETCH || state == WR_COMMIT) && mem_ack) ||
               (state == RD_XFER && data_rd) || (state == WR_XFER && data_wr);
  assign busy = state inside {RD_FETCH, WR_COMMIT, NEXT};
  assign drq = state inside {RD_XFER, WR_XFER};
  assign status = {busy, 1'b1, 2'b00, drq, 2'b00, err};
  assign ide_data_oe = ~sync_s[6] & (sync_s[4:3] == 2'b10);
  assign mem_rd = state == RD_FETCH;
  assign mem_wr = state == WR_COMMIT;
  assign mem_wdata = buffer[ptr];
  assign mem_addr = ADDR_W'({lba, ptr});

  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = go_rd ? RD_FETCH : go_wr ? WR_XFER : IDLE;
      RD_FETCH:  state_n = (mem_ack && last) ? RD_XFER : RD_FETCH;
      RD_XFER:   state_n = (data_rd && last) ? NEXT : RD_XFER;
      WR_XFER:   state_n = (data_wr && last) ? WR_COMMIT : WR_XFER;
      WR_COMMIT: state_n = (mem_ack && last) ? NEXT : WR_COMMIT;
      NEXT:      state_n = (count == 8'd1) ? IDLE : wr_cmd ? WR_XFER : RD_FETCH;
      default:   state_n = IDLE;
    endcase
  end

  always_comb begin
    rd_mux = 16'h0000;
    case (sync_s[2:0])
      3'd0: rd_mux = (state == RD_XFER) ? buffer[ptr] : 16'h0000;
      3'd1: rd_mux = {8'h00, error};
      3'd2: rd_mux = {8'h00, count};
      3'd3: rd_mux = {8'h00, lba[7:0]};
      3'd4: rd_mux = {8'h00, lba[15:8]};
      3'd5: rd_mux = {8'h00, lba[23:16]};
      3'd6: rd_mux = {8'h00, dh_hi, lba[27:24]};
      default: rd_mux = {8'h00, status};
    endcase
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      ptr <= 8'd0;
      count <= 8'd1;
      lba <= 28'd0;
      dh_hi <= 4'd0;
      error <= 8'h00;
      err <= 1'b0;
      wr_cmd <= 1'b0;
      ide_data_out <= 16'h0000;
    end else begin
      state <= state_n;
      ptr <= (go_rd || go_wr) ? 8'd0 : ptr + 8'(adv);
      ide_data_out <= ide_data_oe ? rd_mux : 16'h0000;
      if (state == NEXT) begin
        lba <= lba + 28'd1;
        count <= count - 8'd1;
      end
      if (reg_wr)
        case (sync_p[2:0])
          3'd2: count <= ide_data_in[7:0];
          3'd3: lba[7:0] <= ide_data_in[7:0];
          3'd4: lba[15:8] <= ide_data_in[7:0];
          3'd5: lba[23:16] <= ide_data_in[7:0];
          3'd6: {dh_hi, lba[27:24]} <= ide_data_in[7:0];
          3'd7: begin
            err <= ~(go_rd | go_wr);
            error <= (go_rd | go_wr) ? 8'h00 : 8'h04;
            wr_cmd <= go_wr;
          end
          default: ;
        endcase
    end

  always_ff @(posedge clk)
    if (state == RD_FETCH && mem_ack) buffer[ptr] <= mem_rdata;
    else if (state == WR_XFER && data_wr) buffer[ptr] <= ide_data_in;
endmodule

// File: tb/tb_ide_target.sv
// tb_ide_target: host-bus stimulus with a read scoreboard and a behavioural word memory.
module tb_ide_target;
  logic clk = 0, reset = 1;
  logic [15:0] ide_data_in = 0, ide_data_out, mem_wdata, mem_rdata;
  logic ide_data_oe, ide_dior = 1, ide_diow = 1, mem_rd, mem_wr, mem_ack;
  logic [1:0] ide_cs = 2'b11;
  logic [2:0] ide_da = 0;
  logic [23:0] mem_addr;
  logic [15:0] mem [int];
  logic [15:0] sb_v [$];
  string sb_n [$];
  int errors = 0, checks = 0, rd_cnt = 0, wr_cnt = 0, req_seen = 0, both_cnt = 0;
  int stall = 0, wc = 0, oe_cnt = 0;

  ide_target #(.ADDR_W(24)) dut (
    .clk(clk), .reset(reset), .ide_data_in(ide_data_in), .ide_data_out(ide_data_out),
    .ide_data_oe(ide_data_oe), .ide_dior(ide_dior), .ide_diow(ide_diow), .ide_cs(ide_cs),
    .ide_da(ide_da), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // memory responder: acknowledges one word after `stall` waiting cycles
  initial begin
    mem_ack = 0;
    mem_rdata = 0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 0;
      if (reset) wc = 0;
      else if (mem_rd || mem_wr) begin
        if (wc < stall) wc++;
        else begin
          wc = 0;
          if (mem_rd) begin
            mem_rdata = mem.exists(int'(mem_addr)) ? mem[int'(mem_addr)] : 16'h0000;
            rd_cnt++;
          end else begin
            mem[int'(mem_addr)] = mem_wdata;
            wr_cnt++;
          end
          mem_ack = 1;
        end
      end
    end
  end

  // monitor: samples the driven bus mid-strobe and pops the expected value
  initial forever begin
    @(negedge clk);
    if (mem_rd || mem_wr) req_seen++;
    if (mem_rd && mem_wr) both_cnt++;
    oe_cnt = ide_data_oe ? oe_cnt + 1 : 0;
    if (oe_cnt == 3) begin
      if (sb_v.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read: got %h expected none", ide_data_out);
      end else chk(sb_n.pop_front(), ide_data_out, sb_v.pop_front());
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic host(input logic wr, input logic [2:0] a, input logic [15:0] d, input string n);
    @(negedge clk);
    ide_cs = 2'b10;
    ide_da = a;
    ide_data_in = d;
    if (!wr) begin
      sb_v.push_back(d);
      sb_n.push_back(n);
    end
    @(negedge clk);
    if (wr) ide_diow = 0;
    else ide_dior = 0;
    repeat (6) @(negedge clk);
    ide_diow = 1;
    ide_dior = 1;
    repeat (4) @(negedge clk);
    ide_cs = 2'b11;
  endtask

  task automatic wait_mem(input logic wr, input int target, input int budget, input string n);
    int i = 0;
    while ((wr ? wr_cnt : rd_cnt) < target && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk(n, wr ? wr_cnt : rd_cnt, target);
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic start_read(input logic [7:0] lba0);
    host(1, 3'd2, 16'h0001, "");
    host(1, 3'd3, {8'h00, lba0}, "");
    host(1, 3'd4, 16'h0000, "");
    host(1, 3'd5, 16'h0000, "");
    host(1, 3'd7, 16'h0020, "");
  endtask

  initial begin
    int base, req;
    for (int n = 0; n < 256; n++) mem[(5 << 8) | n] = 16'(n) ^ 16'hA5A5;
    repeat (3) @(negedge clk);
    chk("rst_oe", ide_data_oe, 0);
    chk("rst_dout", ide_data_out, 0);
    chk("rst_memreq", {mem_rd, mem_wr}, 0);
    reset = 0;
    repeat (2) @(negedge clk);
    host(0, 3'd7, 16'h0040, "rst_status");
    host(0, 3'd2, 16'h0001, "rst_count");
    host(0, 3'd1, 16'h0000, "rst_error");

    base = rd_cnt;
    start_read(8'd5);
    host(0, 3'd7, 16'h00C0, "fetch_busy");
    wait_mem(0, base + 256, 2000, "fetch_count");
    host(0, 3'd7, 16'h0048, "rd_drq");
    for (int n = 0; n < 256; n++) host(0, 3'd0, 16'(n) ^ 16'hA5A5, $sformatf("rd_word%0d", n));
    host(0, 3'd7, 16'h0040, "rd_done_status");
    host(0, 3'd2, 16'h0000, "rd_done_count");
    host(0, 3'd3, 16'h0006, "rd_done_lba");

    req = req_seen;
    host(1, 3'd7, 16'h00EC, "");
    host(0, 3'd7, 16'h0041, "badcmd_status");
    host(0, 3'd1, 16'h0004, "badcmd_error");
    chk("badcmd_noreq", req_seen, req);

    base = wr_cnt;
    host(1, 3'd2, 16'h0002, "");
    host(1, 3'd3, 16'h00FF, "");
    host(1, 3'd4, 16'h0000, "");
    host(1, 3'd5, 16'h0000, "");
    host(1, 3'd7, 16'h0030, "");
    host(0, 3'd7, 16'h0048, "wr_drq");
    for (int k = 0; k < 256; k++) host(1, 3'd0, 16'h3C00 ^ 16'(k), "");
    wait_mem(1, base + 256, 2000, "commit1_count");
    for (int k = 256; k < 512; k++) host(1, 3'd0, 16'h3C00 ^ 16'(k), "");
    wait_mem(1, base + 512, 2000, "commit2_count");
    for (int k = 0; k < 512; k++)
      chk($sformatf("mem_word%0d", k), mem.exists(24'hFF00 + k) ? mem[24'hFF00 + k] : 16'hxxxx,
          16'h3C00 ^ 16'(k));
    host(0, 3'd3, 16'h0001, "wr_lba0");
    host(0, 3'd4, 16'h0001, "wr_lba1");
    host(0, 3'd2, 16'h0000, "wr_count");
    host(0, 3'd7, 16'h0040, "wr_status");

    base = rd_cnt;
    start_read(8'd5);
    wait_mem(0, base + 256, 2000, "abort_fetch");
    for (int n = 0; n < 100; n++) host(0, 3'd0, 16'(n) ^ 16'hA5A5, $sformatf("abort_word%0d", n));
    pulse_reset();
    req = req_seen;
    repeat (50) @(negedge clk);
    chk("abort_noreq", req_seen, req);
    host(0, 3'd7, 16'h0040, "abort_status");
    host(0, 3'd2, 16'h0001, "abort_count");
    host(0, 3'd3, 16'h0000, "abort_lba");
    base = rd_cnt;
    start_read(8'd5);
    wait_mem(0, base + 256, 2000, "restart_fetch");
    host(0, 3'd0, 16'hA5A5, "restart_word0");
    host(0, 3'd0, 16'hA5A4, "restart_word1");
    pulse_reset();

    host(0, 3'd0, 16'h0000, "idle_data");
    host(0, 3'd7, 16'h0040, "idle_status");
    stall = 10;
    base = rd_cnt;
    start_read(8'd5);
    wait_mem(0, base + 256, 4000, "stall_fetch");
    for (int n = 0; n < 256; n++) host(0, 3'd0, 16'(n) ^ 16'hA5A5, $sformatf("stall_word%0d", n));
    host(0, 3'd7, 16'h0040, "stall_status");
    stall = 0;

    repeat (10) @(negedge clk);
    chk("sb_drain", sb_v.size(), 0);
    chk("rd_wr_exclusive", both_cnt, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
